alu_sequencer: RTL

//  Multi-cycle ALU controller for the 4-digit calculator. Accepts one operation request

---
 rtl/alu_sequencer_pkg.sv | 30 +++
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_sequencer_iter_core.sv | 107 ++++++++++
 rtl/alu_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared op codes, error codes, FSM encoding and limits for the ALU sequencer
package alu_sequencer_pkg;

  localparam int W_DEF    = 14;
  localparam int MAXV_DEF = 9999;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_OVF   = 2'b01,
    ERR_DIV0  = 2'b10,
    ERR_RANGE = 2'b11
  } err_e;

  // 4-bit encoding so the state can be shared with the main calculator FSM width
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_EXEC  = 4'd2,
    S_CHECK = 4'd3,
    S_DONE  = 4'd4
  } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request/result bundle between the calculator FSM and the ALU sequencer
interface alu_sequencer_if #(
  parameter int W = 14
) ();

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         neg;
  logic         err;
  logic [1:0]   err_code;

  // calculator FSM side
  modport master (
    output start, op, a, b,
    input  busy, done, result, neg, err, err_code
  );

  // ALU sequencer side
  modport slave (
    input  start, op, a, b,
    output busy, done, result, neg, err, err_code
  );

endinterface

// File: rtl/alu_sequencer_iter_core.sv
// rtl/alu_sequencer_iter_core.sv - accumulator, shift registers and iteration counter for the ALU
module alu_iter_core
  import alu_sequencer_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  op_e            op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] acc,
  output logic           last
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  op_e            op_q, op_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each mul step
  logic [W-1:0]   mplier_q, mplier_d; // multiplier, consumed LSB first
  logic [W-1:0]   x_q, x_d;           // operand a; dividend bits leave from the MSB during div
  logic [W-1:0]   y_q, y_d;           // operand b; also the divisor
  logic [W-1:0]   rem_q, rem_d;       // partial remainder for restoring division
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W:0]     rem_sh;
  logic           q_bit;

  // datapath registers; reset clears accumulator and iteration counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_ADD;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

  // load captures the operands; each step does one add/sub or one mul/div iteration
  always_comb begin
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    x_d      = x_q;
    y_d      = y_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    rem_sh   = {rem_q, x_q[W-1]};
    q_bit    = 1'b0;

    if (load) begin
      op_d     = op;
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      x_d      = a;
      y_d      = b;
      rem_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      case (op_q)
        OP_ADD: acc_d = {{W{1'b0}}, x_q} + {{W{1'b0}}, y_q};
        OP_SUB: acc_d = (x_q >= y_q) ? {{W{1'b0}}, x_q - y_q} : {{W{1'b0}}, y_q - x_q};
        OP_MUL: begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        OP_DIV: begin
          // trial subtract; keep the shifted remainder when the divisor does not fit
          if (rem_sh >= {1'b0, y_q}) begin
            rem_d = W'(rem_sh - {1'b0, y_q});
            q_bit = 1'b1;
          end else begin
            rem_d = rem_sh[W-1:0];
          end
          x_d   = x_q << 1;
          acc_d = {acc_q[2*W-2:0], q_bit};
        end
        default: acc_d = acc_q;
      endcase
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle ALU controller: FSM, operand checks and held result registers
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int MAXV = MAXV_DEF
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  localparam logic [W-1:0]   MAXV_W   = W'(MAXV);
  localparam logic [2*W-1:0] MAXV_ACC = (2*W)'(MAXV);

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic         lt_q, lt_d;             // a < b at load time, gives the sub sign
  err_e         ecode_q, ecode_d;       // error found during LOAD, pending until CHECK
  logic [W-1:0] result_q, result_d;
  logic         neg_q, neg_d;
  logic         err_q, err_d;
  err_e         err_code_q, err_code_d;

  op_e            op_in;
  logic           range_bad;
  logic           div_zero;
  err_e           chk_code;
  logic           core_load;
  logic           core_step;
  logic [2*W-1:0] acc;
  logic           last;

  assign op_in     = op_e'(bus.op);
  assign range_bad = (bus.a > MAXV_W) || (bus.b > MAXV_W);
  assign div_zero  = (op_in == OP_DIV) && (bus.b == '0);

  alu_iter_core #(.W(W)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (core_load),
    .step  (core_step),
    .op    (op_in),
    .a     (bus.a),
    .b     (bus.b),
    .acc   (acc),
    .last  (last)
  );

  // state and result registers; reset aborts any operation without a done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ADD;
      lt_q       <= 1'b0;
      ecode_q    <= ERR_NONE;
      result_q   <= '0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      lt_q       <= lt_d;
      ecode_q    <= ecode_d;
      result_q   <= result_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // next state: LOAD errors skip EXEC; add/sub take one EXEC cycle, mul/div run until last
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = (range_bad || div_zero) ? S_CHECK : S_EXEC;
      S_EXEC:  if (op_q == OP_ADD || op_q == OP_SUB || last) state_d = S_CHECK;
      S_CHECK: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // operand checks in LOAD and result/error update in CHECK; overflow uses the full accumulator
  always_comb begin
    op_d       = op_q;
    lt_d       = lt_q;
    ecode_d    = ecode_q;
    result_d   = result_q;
    neg_d      = neg_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    chk_code   = ((ecode_q == ERR_NONE) && (acc > MAXV_ACC)) ? ERR_OVF : ecode_q;

    if (state_q == S_LOAD) begin
      op_d = op_in;
      lt_d = (bus.a < bus.b);
      if (range_bad)     ecode_d = ERR_RANGE;
      else if (div_zero) ecode_d = ERR_DIV0;
      else               ecode_d = ERR_NONE;
    end

    if (state_q == S_CHECK) begin
      err_code_d = chk_code;
      if (chk_code != ERR_NONE) begin
        result_d = '0;
        err_d    = 1'b1;
        neg_d    = 1'b0;
      end else begin
        result_d = acc[W-1:0];
        err_d    = 1'b0;
        neg_d    = (op_q == OP_SUB) && lt_q;
      end
    end
  end

  // status and core controls decoded from the current state
  always_comb begin
    bus.busy  = (state_q != S_IDLE);
    bus.done  = (state_q == S_DONE);
    core_load = (state_q == S_LOAD);
    core_step = (state_q == S_EXEC);
  end

  assign bus.result   = result_q;
  assign bus.neg      = neg_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule
